pipe_reg: RTL and testbench

Parametrised, elastic register pipeline: the multi-bit, multi-stage successor to the team's single-bit D flip-flop. It carries a WIDTH-bit word through DEPTH register stages under a valid/ready handshake, with per-stage valid bits. It also supports bubble collapsing under back-pressure, a synchronous flush and an occupancy count. It sits between any producer/consumer pair that needs fixed retiming with stall tolerance.

---
 rtl/pipe_reg.sv | 108 ++++++++++
 tb/tb_pipe_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg.sv
// pipe_reg -- elastic register pipeline.
//
// Carries a WIDTH-bit word through DEPTH register stages. Each stage has its
// own valid bit, so bubbles are squeezed out while the output is stalled and
// the pipe can fill to DEPTH words.
//
// Parameters:
//   WIDTH      data word width in bits (>=1)
//   DEPTH      number of register stages (>=1)
//   RESET_VAL  value loaded into every data register on reset
//   CW         width of the occupancy count (derived)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (wins over flush and handshakes)
//   flush      synchronous clear of all valid bits; data registers hold
//   in_valid   producer has a word
//   in_ready   pipeline accepts a word this cycle
//   in_data    producer word
//   out_valid  last stage holds a word
//   out_ready  consumer takes the word this cycle
//   out_data   word in the last stage
//   count      number of valid stages (0..DEPTH)
//
// Handshake: a word moves across an interface only on a rising edge where
// valid and ready are both high. A producer holds valid and data until it
// sees ready. A consumer may look at out_data whenever out_valid is high, and
// out_data stays stable until it is taken. in_ready depends combinationally
// on out_ready. No combinational path runs from in_valid or in_data to any
// output.

module pipe_reg #(
  parameter int                 WIDTH     = 8,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  // Per-stage state. Stage 0 is the input side and stage DEPTH-1 is the output.
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  // rdy[i]: stage i may load on this edge. Its current content is either a
  // bubble or is itself moving on.
  logic [DEPTH-1:0] rdy;

  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = !v[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      rdy[i] = !v[i] | rdy[i+1];
    end
  end

  // Flush closes the input for its cycle so no word can slip in behind the
  // clear. The producer keeps holding that word.
  assign in_ready = rdy[0] & !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESET_VAL;
      end
    end else begin
      if (flush) begin
        // Only the valid bits are cleared. The data registers keep their
        // contents, which saves a wide mux on every stage.
        v <= '0;
      end else begin
        if (rdy[0]) begin
          v[0] <= in_valid & in_ready;
          d[0] <= in_data;
        end
        for (int i = 1; i < DEPTH; i++) begin
          if (rdy[i]) begin
            v[i] <= v[i-1];
            d[i] <= d[i-1];
          end
        end
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // Occupancy is a popcount of registered valid bits. It can never exceed
  // DEPTH, and CW is sized to hold DEPTH itself.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(v[i]);
    end
  end

endmodule

// File: tb/tb_pipe_reg.sv
// Directed bench for pipe_reg (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5).

module tb_pipe_reg;

  localparam int               WIDTH = 8;
  localparam int               DEPTH = 3;
  localparam logic [WIDTH-1:0] RV    = 8'hA5;
  localparam int               CW    = $clog2(DEPTH + 1);

  // clock / reset
  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  always #5 clk = ~clk;

  pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  int vectors = 0;
  int errors  = 0;

  // Advance one edge and sample 1 time unit later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // ---- reset / idle ----
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'hA5);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // ---- streaming 01..05, out_ready high ----
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      if (cyc <= 5) push(WIDTH'(cyc));
      else          in_valid = 1'b0;
      settle();
      if (cyc <= 5) chk("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      // A word accepted on edge cyc shows up after edge cyc+2.
      if (cyc >= 3) begin
        chk("stream_out_valid", 32'(out_valid), 32'd1);
        chk("stream_out_data",  32'(out_data),  32'(cyc - 2));
      end else begin
        chk("stream_out_valid", 32'(out_valid), 32'd0);
      end
      chk("stream_count", 32'(count),
          (cyc <= 2) ? 32'(cyc) : (cyc <= 5) ? 32'd3 : 32'(8 - cyc));
    end
    tick();
    chk("stream_drained_valid", 32'(out_valid), 32'd0);
    chk("stream_drained_count", 32'(count),     32'd0);

    // ---- back-pressure fill ----
    out_ready = 1'b0;
    push(8'h10); tick();
    push(8'h11); tick();
    push(8'h12); tick();
    chk("bp_count_full", 32'(count),    32'd3);
    chk("bp_out_data",   32'(out_data), 32'h10);
    push(8'h13);
    settle();
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold_count", 32'(count),    32'd3);
    chk("bp_hold_data",  32'(out_data), 32'h10);
    out_ready = 1'b1;
    settle();
    chk("bp_in_ready_release", 32'(in_ready), 32'd1);
    tick();
    // 10 delivered and 13 accepted on the same edge.
    chk("bp_count_swap", 32'(count),    32'd3);
    chk("bp_out_11",     32'(out_data), 32'h11);
    in_valid = 1'b0;
    tick();
    chk("bp_out_12", 32'(out_data), 32'h12);
    tick();
    chk("bp_out_13",   32'(out_data),  32'h13);
    chk("bp_valid_13", 32'(out_valid), 32'd1);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // ---- bubble collapse ----
    out_ready = 1'b0;
    push(8'h20); tick();
    in_valid = 1'b0; tick();
    push(8'h21); tick();
    chk("bub_count_accepted", 32'(count), 32'd2);
    in_valid = 1'b0; tick();
    chk("bub_count", 32'(count),    32'd2);
    chk("bub_v",     32'(dut.v),    32'b110);
    chk("bub_out20", 32'(out_data), 32'h20);
    out_ready = 1'b1;
    tick();
    chk("bub_out21",   32'(out_data),  32'h21);
    chk("bub_valid21", 32'(out_valid), 32'd1);
    tick();
    chk("bub_empty", 32'(out_valid), 32'd0);

    // ---- flush ----
    out_ready = 1'b0;
    push(8'h30); tick();
    push(8'h31); tick();
    push(8'h32); tick();
    chk("fl_count_full", 32'(count), 32'd3);
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    push(8'h33);
    settle();
    chk("fl_in_ready",   32'(in_ready),  32'd0);
    chk("fl_out_valid",  32'(out_valid), 32'd1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    settle();
    chk("fl_count",      32'(count),     32'd0);
    chk("fl_out_valid0", 32'(out_valid), 32'd0);
    chk("fl_data_hold",  32'(out_data),  32'h30);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fl_no_33", 32'(out_valid), 32'd0);
    end

    // ---- mid-stream reset ----
    push(8'h50); tick();
    push(8'h51); tick();
    push(8'h52); tick();
    chk("mr_count_pre", 32'(count), 32'd3);
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("mr_count",    32'(count),     32'd0);
    chk("mr_out_data", 32'(out_data),  32'hA5);
    chk("mr_valid",    32'(out_valid), 32'd0);
    push(8'h40); tick();
    in_valid = 1'b0;
    chk("mr_lat1", 32'(out_valid), 32'd0);
    tick();
    chk("mr_lat2", 32'(out_valid), 32'd0);
    tick();
    chk("mr_out40_valid", 32'(out_valid), 32'd1);
    chk("mr_out40_data",  32'(out_data),  32'h40);
    tick();
    chk("mr_empty", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
